// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU and a DMA requester.
// Each access runs IDLE -> ACCESS -> DONE; the DMA port can lock the grant for bursts.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  logic [1:0]        r_state;
  logic [1:0]        r_owner;
  logic              r_last_dma;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic w_any_req;
  logic w_grant_dma;

  assign w_any_req = cpu_req | dma_req;
  // DMA wins when alone, when the CPU was served last, or when it holds the burst lock.
  assign w_grant_dma = dma_req & (~cpu_req | ~r_last_dma | dma_lock);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_last_dma  <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_ACCESS;
            r_owner    <= w_grant_dma ? OWN_DMA : OWN_CPU;
            r_last_dma <= w_grant_dma;
            r_we       <= w_grant_dma ? dma_we    : cpu_we;
            r_addr     <= w_grant_dma ? dma_addr  : cpu_addr;
            r_wdata    <= w_grant_dma ? dma_wdata : cpu_wdata;
          end
        end
        S_ACCESS: begin
          r_state <= S_DONE;
          if (!r_we) begin
            if (r_owner == OWN_DMA) r_dma_rdata <= mem_rdata;
            else                    r_cpu_rdata <= mem_rdata;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  // NOTE: strobes decode straight from the async-reset state, so reset cuts mem_we and ack at once.
  assign mem_we    = (r_state == S_ACCESS) & r_we;
  assign cpu_ack   = (r_state == S_DONE) & (r_owner == OWN_CPU);
  assign dma_ack   = (r_state == S_DONE) & (r_owner == OWN_DMA);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4096x16 memory and an in-order ack scoreboard.
// Stimulus pushes the expected completions; a negedge monitor pops and checks each ack.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // Memory model: combinational read, write on the rising edge; preload only while reset is first held.
  logic [DW-1:0] mem [4096];
  logic          preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      mem[12'h015] <= 16'h0001;
      mem[12'h017] <= 16'h010E;
      mem[12'h020] <= 16'h0000;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          dma;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input bit dma, input bit rd, input logic [15:0] data);
    exp_t e;
    e.dma  = dma;
    e.rd   = rd;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Waits for the given ack; reports how many negedges passed without it.
  task automatic wait_ack(input bit dma, input int exp_wait, input string name);
    int n = 0;
    while (n <= 20) begin
      @(negedge clk);
      if (dma ? dma_ack : cpu_ack) break;
      n++;
    end
    check(name, 32'(n), 32'(exp_wait));
  endtask

  task automatic release_req(input bit dma);
    @(posedge clk);
    #1;
    if (dma) dma_req = 1'b0;
    else     cpu_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && (cpu_ack || dma_ack)) begin
      check("ack_exclusive", 32'(cpu_ack & dma_ack), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, dma_ack, cpu_ack}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("ack_port", 32'(dma_ack), 32'(mon_e.dma));
        check("ack_owner", 32'(owner), mon_e.dma ? 32'd2 : 32'd1);
        if (mon_e.rd) begin
          if (mon_e.dma) check("dma_rdata", 32'(dma_rdata), 32'(mon_e.data));
          else           check("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_owner",     32'(owner),     32'd0);
    check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    check("rst_dma_ack",   32'(dma_ack),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    preload = 1'b0;

    // Tie after reset: CPU, then DMA, then CPU again
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h015;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h017;
    expect_ack(1'b0, 1'b1, 16'h0001);
    expect_ack(1'b1, 1'b1, 16'h010E);
    expect_ack(1'b0, 1'b1, 16'h0001);
    wait_ack(1'b0, 2, "tie_cpu_first");
    wait_ack(1'b1, 2, "tie_dma_second");
    release_req(1'b1);
    wait_ack(1'b0, 2, "tie_cpu_third");
    release_req(1'b0);

    // CPU write then read, cycle by cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h00D; cpu_wdata = 16'h0087;
    expect_ack(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("wr_we_idle", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("wr_we_access", 32'(mem_we),    32'd1);
    check("wr_addr",      32'(mem_addr),  32'h00D);
    check("wr_wdata",     32'(mem_wdata), 32'h0087);
    check("wr_owner",     32'(owner),     32'd1);
    @(negedge clk);
    check("wr_ack",        32'(cpu_ack),   32'd1);
    check("wr_we_done",    32'(mem_we),    32'd0);
    check("wr_keep_rdata", 32'(cpu_rdata), 32'h0001);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    expect_ack(1'b0, 1'b1, 16'h0087);
    wait_ack(1'b0, 2, "rd_latency");
    release_req(1'b0);
    check("wr_mem_00d", 32'(mem[12'h00D]), 32'h0087);

    // DMA burst lock with the CPU requesting throughout
    dma_lock = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h100; dma_wdata = 16'hA000;
    cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h00D;
    for (int i = 0; i < 4; i++) expect_ack(1'b1, 1'b0, 16'h0000);
    expect_ack(1'b0, 1'b1, 16'h0087);
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b1, 2, "burst_dma_lat");
      @(posedge clk);
      #1;
      if (i < 3) begin
        dma_addr  = 12'(12'h100 + i + 1);
        dma_wdata = 16'(16'hA000 + i + 1);
      end else begin
        dma_req  = 1'b0;
        dma_lock = 1'b0;
      end
    end
    wait_ack(1'b0, 2, "burst_cpu_after_unlock");
    release_req(1'b0);
    for (int i = 0; i < 4; i++)
      check("burst_mem", 32'(mem[12'(12'h100 + i)]), 32'(16'hA000 + i));

    // Held non-owner request rising during a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h040; cpu_wdata = 16'h1234;
    expect_ack(1'b0, 1'b0, 16'h0000);
    expect_ack(1'b1, 1'b1, 16'h0001);
    @(posedge clk);
    #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h015;
    wait_ack(1'b0, 1, "held_cpu_ack");
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("held_idle_owner", 32'(owner), 32'd0);
    @(negedge clk);
    check("held_dma_owner", 32'(owner),    32'd2);
    check("held_dma_addr",  32'(mem_addr), 32'h015);
    wait_ack(1'b1, 0, "held_dma_ack");
    release_req(1'b1);
    check("held_mem_040", 32'(mem[12'h040]), 32'h1234);

    // Reset asserted during a DMA write's ACCESS cycle
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h020; dma_wdata = 16'hBEEF;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_we_before", 32'(mem_we), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("abort_we_drop",   32'(mem_we),   32'd0);
    check("abort_owner",     32'(owner),    32'd0);
    check("abort_dma_ack",   32'(dma_ack),  32'd0);
    check("abort_mem_addr",  32'(mem_addr), 32'd0);
    dma_req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mem_020",   32'(mem[12'h020]), 32'h0000);
    check("abort_dma_rdata", 32'(dma_rdata),    32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_ack", 32'(dma_ack), 32'd0);
    check("sb_drained",   32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 4096x16 main memory between the CPU datapath and a DMA/I-O requester. Sits directly in front of the memory block: it owns that block's address, write-data and write-enable inputs and receives its combinational read data. Each access is a three-state sequence with a registered request/acknowledge handshake per requester. Grants use round-robin between the two requesters, with an optional DMA burst lock.

## Interface
- ADDR_W, 12, memory address width
- DATA_W, 16, memory word width
- clk  in  1  single clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  registered read data, valid in the cpu_ack cycle and held until the next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same semantics as the CPU port
- dma_lock  in  1  burst lock; keeps the DMA grant across consecutive DMA requests
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  DATA_W  same rules as cpu_rdata
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory DATA
- mem_we  out  1  to memory w_enable
- mem_rdata  in  DATA_W  from memory read_data (combinational)
- owner  out  2  00 none, 01 CPU, 10 DMA; nonzero in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata into internal registers, set owner, go to ACCESS.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high, last_owner = DMA and dma_lock = 1: DMA wins.
  - Both high otherwise: the requester that is not last_owner wins.
  - last_owner updates on every grant. Its reset value is DMA, so the CPU wins the first tie.
  - dma_lock has no effect when dma_req is low.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched we, decoded from the state.
  - At the closing edge: a write commits in memory; for a read, mem_rdata is captured into the owner's rdata register.
  - Next state: DONE.
- DONE:
  - Owner's ack = 1; mem_we = 0.
  - Requests are not sampled in DONE.
  - Next state: IDLE.
  - The requester drops req on the edge closing DONE, or keeps it high to issue a new request, which is sampled in IDLE.
- Writes leave the port's rdata register unchanged.
- mem_addr and mem_wdata hold their latched values outside ACCESS.
- A non-owner's req may stay high indefinitely; its request waits in IDLE arbitration and is never lost.

## Timing
- Access latency: req sampled in IDLE at cycle N; memory accessed in N+1; ack and rdata valid in N+2.
- Throughput: one access per 3 cycles. Back-to-back requests from the same port take 3 cycles each.
- Reset values:
  - state IDLE, owner 00, last_owner DMA.
  - cpu_ack, dma_ack and mem_we are 0.
  - cpu_rdata, dma_rdata, mem_addr and mem_wdata are 0.
- Reset asserted during ACCESS:
  - mem_we drops asynchronously, so no write commits.
  - No ack is ever issued for the aborted access.
  - The requester must re-issue after reset.
- Reset asserted during DONE: the ack is cut short; the write has already committed.
- Simultaneous requests in IDLE are resolved by the winner-selection rules in Operation; the loser is served in the next IDLE window unless the lock applies.
- The ack outputs are never both high. owner is never 11.

## Test plan
- CPU write then read: cpu_req, we = 1, addr 0x00D, wdata 0x0087, then a read of 0x00D. Required: mem_we high exactly one cycle (N+1), cpu_ack at N+2, read returns cpu_rdata = 0x0087 in its ack cycle.
- Tie after reset: both ports request reads of 0x015 and 0x017 (preloaded 0x0001 / 0x010E) and hold req. Required: CPU served first (cpu_rdata 0x0001), then DMA (dma_rdata 0x010E), then CPU again if still requesting.
- DMA burst lock: dma_lock = 1, DMA issues 4 consecutive writes to 0x100–0x103, cpu_req held high throughout. Required: all 4 dma_acks before any cpu_ack; CPU served immediately after dma_lock drops.
- Reset mid-write: DMA write of 0xBEEF to 0x020 (preloaded 0x0000), reset asserted during ACCESS before the edge. Required: mem_we falls immediately, memory 0x020 stays 0x0000, no dma_ack, owner = 00.
- Held non-owner request: CPU write in progress while dma_req rises in ACCESS. Required: DMA granted in the first IDLE cycle after cpu_ack, dma_ack exactly 3 cycles later, no request dropped.
